man_dist_engine: RTL and testbench
==================================

// Module: man_dist_engine
// PURPOSE
//  Upstream producer for the UART byte-serialiser (interface signals en_txMAN, man, done_txMAN).
//  - Streams two ELEM_W-bit vectors (A, B) out of dual BRAMs and accumulates sum|A[i]-B[i]|.
//  - Publishes the 32-bit Manhattan distance on man with a 1-cycle en_txMAN pulse.
//  - Holds man until the serialiser returns done_txMAN.
// PARAMETERS
//  N_ELEM  1024                 vector length, elements; legal range 1..65535
//  ELEM_W  8                    element width, unsigned
//  RD_LAT  2                    BRAM read latency in cycles, rd_en to a_data/b_data valid; >=1
//  ADDR_W  $clog2(N_ELEM) (min 1)  address width
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       compute request; sampled only in IDLE
//  rd_en       out  1       BRAM read enable, both vectors
//  addr        out  ADDR_W  BRAM read address, shared by A and B
//  a_data      in   ELEM_W  vector A element, valid RD_LAT cycles after rd_en
//  b_data      in   ELEM_W  vector B element, same timing as a_data
//  man         out  32      Manhattan distance, zero-extended; stable from en_txMAN until next start
//  en_txMAN    out  1       1-cycle pulse: man valid, serialiser may begin
//  done_txMAN  in   1       serialiser finished sending the 4 bytes of man
//  busy        out  1       high in every state except IDLE
//  done        out  1       1-cycle pulse on return to IDLE after done_txMAN
// BEHAVIOUR
//  Reset values: rd_en=0, addr=0, man=0, en_txMAN=0, busy=0, done=0; accumulator=0; valid pipe=0; state=IDLE.
//  States and transitions:
//   IDLE    -> ISSUE on start. Same edge: accumulator cleared, addr=0. man keeps its previous value.
//   ISSUE   rd_en=1 for exactly N_ELEM consecutive cycles; addr = 0..N_ELEM-1, +1 per cycle.
//           -> DRAIN after the read with addr=N_ELEM-1; addr returns to 0.
//   DRAIN   rd_en=0; wait until the RD_LAT-deep valid shift pipe and the abs-diff stage are empty.
//           -> PUBLISH on that condition.
//   PUBLISH man <= accumulator; en_txMAN=1 for this one cycle only. -> WAIT_TX.
//   WAIT_TX en_txMAN=0. -> IDLE on done_txMAN, with done=1 for one cycle.
//  Datapath:
//   - Stage 1 (registered): d = (a>=b) ? a-b : b-a, ELEM_W bits, unsigned, never negative.
//   - Stage 2: acc += d. Accumulator is 32 bits; max sum with defaults is 261120, so no overflow.
//   - Upper bits of man are zero.
//  Latency: with start sampled at cycle 0, en_txMAN is high in cycle N_ELEM+RD_LAT+3.
//   The MAN_PIPE_REG_EN macro adds 1 cycle.
//  Boundaries:
//   - start outside IDLE: ignored, not queued.
//   - done_txMAN outside WAIT_TX: ignored.
//   - start and done_txMAN in the same WAIT_TX cycle: go to IDLE; start is dropped.
//   - Reset mid-operation: back to IDLE on the next edge with all reset values; any pending transfer is abandoned.
//   - N_ELEM=1: ISSUE lasts exactly one cycle.
//   - a==b for all elements: man=0, and en_txMAN still pulses.
// CONFIGURATION
//  MAN_PIPE_REG_EN
//   - Defined: an extra register between stage 1 and stage 2 (timing closure). Valid pipe +1; latency +1.
//   - Undefined: abs-diff feeds the accumulator directly. Function identical either way; only latency differs.
// STRUCTURE
//  - man_pkg: state enum (IDLE, ISSUE, DRAIN, PUBLISH, WAIT_TX); localparam ACC_W=32;
//    function absdiff(a,b).
//  - Sub-module man_absdiff: registered |a-b| plus its valid flag.
//    FSM, address counter, valid pipe and accumulator live in man_dist_engine.
// TESTING
//  Bench BRAM model honours RD_LAT. The serialiser model asserts done_txMAN 40 cycles after en_txMAN.
//  1. N_ELEM=4, A={10,20,30,40}, B={40,20,10,45}
//     -> man=55 (30+0+20+5); en_txMAN 1 cycle at cycle N+RD_LAT+3=9; done pulses after done_txMAN.
//  2. Defaults, A=all 255, B=all 0
//     -> man=261120 (0x0003FC00); addr sweeps 0..1023 contiguously with rd_en high 1024 cycles.
//  3. A==B -> man=0; en_txMAN still pulses; done follows done_txMAN.
//  4. start pulsed in ISSUE and in WAIT_TX; done_txMAN pulsed in ISSUE
//     -> all ignored; a single result is produced.
//  5. reset asserted mid-ISSUE at addr=100
//     -> next cycle all outputs at reset values; a fresh start yields the correct man.
//  6. Rerun test 1 with MAN_PIPE_REG_EN defined
//     -> identical man; en_txMAN one cycle later (cycle 10).

Source files
------------

// File: rtl/man_pkg.sv
// ---------------------------------------------------------------------------
// man_pkg
//   Shared definitions for the Manhattan-distance engine.
//   - man_state_e : control FSM states
//   - ACC_W       : accumulator / result width
//   - ABS_MAX_W   : widest element the absdiff helper accepts
//   - absdiff()   : unsigned |a-b| that never goes negative
// ---------------------------------------------------------------------------
package man_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        PUBLISH = 3'd3,
        WAIT_TX = 3'd4
    } man_state_e;

    localparam int ACC_W     = 32;
    localparam int ABS_MAX_W = 32;

    // Subtract the smaller operand from the larger so the result is never negative.
    function automatic logic [ABS_MAX_W-1:0] absdiff(
        input logic [ABS_MAX_W-1:0] a,
        input logic [ABS_MAX_W-1:0] b
    );
        logic [ABS_MAX_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/man_absdiff.sv
// ---------------------------------------------------------------------------
// man_absdiff
//   Registered absolute-difference stage with its valid flag.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     in_valid     : a/b carry a real element this cycle
//     a, b         : ELEM_W-bit unsigned operands
//     diff         : registered |a-b|
//     diff_valid   : registered copy of in_valid
// ---------------------------------------------------------------------------
module man_absdiff
    import man_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] diff,
    output logic              diff_valid
);

    logic [ELEM_W-1:0] diff_d, diff_q;
    logic              valid_d, valid_q;

    // Next-state: |a-b| fits in ELEM_W bits, so the narrowing cast loses nothing.
    always_comb begin
        diff_d  = ELEM_W'(absdiff(ABS_MAX_W'(a), ABS_MAX_W'(b)));
        valid_d = in_valid;
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            diff_q  <= diff_d;
            valid_q <= valid_d;
        end
    end

    assign diff       = diff_q;
    assign diff_valid = valid_q;

endmodule

// File: rtl/man_dist_engine.sv
// ---------------------------------------------------------------------------
// man_dist_engine
//   Streams vectors A and B from two BRAMs sharing one address, accumulates
//   sum |A[i]-B[i]| and hands the 32-bit result to the UART serialiser.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     start               : compute request, only looked at in IDLE
//     rd_en, addr         : BRAM read enable / shared address
//     a_data, b_data      : BRAM outputs, valid RD_LAT cycles after rd_en
//     man                 : result, zero-extended, held until the next start
//     en_txMAN            : one-cycle pulse, man is valid
//     done_txMAN          : serialiser finished, honoured only in WAIT_TX
//     busy                : high outside IDLE
//     done                : one-cycle pulse on return to IDLE
//   Build option:
//     MAN_PIPE_REG_EN     : adds a register between |a-b| and the accumulator
//                           (one extra cycle of latency, same result).
// ---------------------------------------------------------------------------
module man_dist_engine
    import man_pkg::*;
#(
    parameter int N_ELEM = 1024,
    parameter int ELEM_W = 8,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    input  logic [ELEM_W-1:0] a_data,
    input  logic [ELEM_W-1:0] b_data,
    output logic [31:0]       man,
    output logic              en_txMAN,
    input  logic              done_txMAN,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

    man_state_e        state_d, state_q;
    logic              rd_en_d, rd_en_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ACC_W-1:0]  acc_d, acc_q;
    logic [31:0]       man_d, man_q;
    logic              en_tx_d, en_tx_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic [RD_LAT-1:0] vpipe_d, vpipe_q;

    logic [ELEM_W-1:0] d1;
    logic              d1_valid;
    logic [ELEM_W-1:0] stage_diff;
    logic              stage_valid;
    logic              pipe_busy;

    // Stage 1: registered |a-b|, qualified by the tail of the valid pipe.
    man_absdiff #(
        .ELEM_W (ELEM_W)
    ) u_absdiff (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (vpipe_q[RD_LAT-1]),
        .a          (a_data),
        .b          (b_data),
        .diff       (d1),
        .diff_valid (d1_valid)
    );

`ifdef MAN_PIPE_REG_EN
    logic [ELEM_W-1:0] d2_d, d2_q;
    logic              d2_valid_d, d2_valid_q;

    // Next-state for the optional retiming register.
    always_comb begin
        d2_d       = d1;
        d2_valid_d = d1_valid;
    end

    // Optional retiming register between stage 1 and the accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            d2_q       <= '0;
            d2_valid_q <= 1'b0;
        end else begin
            d2_q       <= d2_d;
            d2_valid_q <= d2_valid_d;
        end
    end

    assign stage_diff  = d2_q;
    assign stage_valid = d2_valid_q;
    assign pipe_busy   = (vpipe_q != '0) || d1_valid || d2_valid_q;
`else
    assign stage_diff  = d1;
    assign stage_valid = d1_valid;
    assign pipe_busy   = (vpipe_q != '0) || d1_valid;
`endif

    // Control FSM, address counter, valid pipe and accumulator next-state.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        man_d   = man_q;
        en_tx_d = 1'b0;
        done_d  = 1'b0;

        // The valid pipe mirrors rd_en so it lines up with the BRAM read latency;
        // the oldest bit falls off the top.
        vpipe_d = RD_LAT'({vpipe_q, rd_en_q});

        if (stage_valid) begin
            acc_d = acc_q + ACC_W'(stage_diff);
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                    acc_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                    addr_d  = '0;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Result is loaded on entry to PUBLISH so man is already valid
                // in the cycle en_txMAN is high.
                if (!pipe_busy) begin
                    state_d = PUBLISH;
                    man_d   = 32'(acc_q);
                    en_tx_d = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            PUBLISH: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                // A start arriving alongside done_txMAN is dropped.
                if (done_txMAN) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT_TX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Control and datapath state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            acc_q   <= '0;
            man_q   <= 32'd0;
            en_tx_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            man_q   <= man_d;
            en_tx_q <= en_tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vpipe_q <= vpipe_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign addr     = addr_q;
    assign man      = man_q;
    assign en_txMAN = en_tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_man_dist_engine.sv
// ---------------------------------------------------------------------------
// tb_man_dist_engine
//   Three engine instances: a 4-element one for the vector table and the
//   control corner cases, a default 1024-element one for the full sweep and
//   the mid-run reset, and a 1-element one with RD_LAT=1.
// ---------------------------------------------------------------------------
module tb_man_dist_engine;

`ifdef MAN_PIPE_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int SER_GAP = 40;
    localparam int LAT_S   = 4 + 2 + 3 + EXTRA;
    localparam int LAT_D   = 1024 + 2 + 3 + EXTRA;
    localparam int LAT_1   = 1 + 1 + 3 + EXTRA;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- small instance: N_ELEM=4, RD_LAT=2 ----------------
    logic        start_s, done_tx_s, rd_en_s, en_s, busy_s, done_s;
    logic [1:0]  addr_s;
    logic [7:0]  a_s, b_s;
    logic [31:0] man_s;
    logic [7:0]  mem_a_s [4];
    logic [7:0]  mem_b_s [4];
    logic [7:0]  pa_s [2];
    logic [7:0]  pb_s [2];

    man_dist_engine #(.N_ELEM(4), .ELEM_W(8), .RD_LAT(2)) u_s (
        .clk(clk), .reset(reset), .start(start_s), .rd_en(rd_en_s), .addr(addr_s),
        .a_data(a_s), .b_data(b_s), .man(man_s), .en_txMAN(en_s),
        .done_txMAN(done_tx_s), .busy(busy_s), .done(done_s));

    // Junk on idle reads exposes any accumulation outside the valid window.
    always @(posedge clk) begin
        pa_s[0] <= rd_en_s ? mem_a_s[addr_s] : 8'hA5;
        pb_s[0] <= rd_en_s ? mem_b_s[addr_s] : 8'h00;
        pa_s[1] <= pa_s[0];
        pb_s[1] <= pb_s[0];
    end
    assign a_s = pa_s[1];
    assign b_s = pb_s[1];

    // ---------------- default instance: N_ELEM=1024, RD_LAT=2 ----------------
    logic        start_d, done_tx_d, rd_en_d, en_d, busy_d, done_d;
    logic [9:0]  addr_d;
    logic [7:0]  a_d, b_d;
    logic [31:0] man_d;
    logic [7:0]  mem_a_d [1024];
    logic [7:0]  mem_b_d [1024];
    logic [7:0]  pa_d [2];
    logic [7:0]  pb_d [2];

    man_dist_engine u_d (
        .clk(clk), .reset(reset), .start(start_d), .rd_en(rd_en_d), .addr(addr_d),
        .a_data(a_d), .b_data(b_d), .man(man_d), .en_txMAN(en_d),
        .done_txMAN(done_tx_d), .busy(busy_d), .done(done_d));

    always @(posedge clk) begin
        pa_d[0] <= rd_en_d ? mem_a_d[addr_d] : 8'hA5;
        pb_d[0] <= rd_en_d ? mem_b_d[addr_d] : 8'h00;
        pa_d[1] <= pa_d[0];
        pb_d[1] <= pb_d[0];
    end
    assign a_d = pa_d[1];
    assign b_d = pb_d[1];

    // ---------------- single-element instance: N_ELEM=1, RD_LAT=1 ----------------
    logic        start_1, done_tx_1, rd_en_1, en_1, busy_1, done_1;
    logic [0:0]  addr_1;
    logic [7:0]  a_1, b_1;
    logic [31:0] man_1;

    man_dist_engine #(.N_ELEM(1), .ELEM_W(8), .RD_LAT(1)) u_1 (
        .clk(clk), .reset(reset), .start(start_1), .rd_en(rd_en_1), .addr(addr_1),
        .a_data(a_1), .b_data(b_1), .man(man_1), .en_txMAN(en_1),
        .done_txMAN(done_tx_1), .busy(busy_1), .done(done_1));

    always @(posedge clk) begin
        a_1 <= (rd_en_1 && addr_1 == 1'b0) ? 8'd7   : 8'hA5;
        b_1 <= (rd_en_1 && addr_1 == 1'b0) ? 8'd200 : 8'h00;
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [7:0]  a [4];
        logic [7:0]  b [4];
        logic [31:0] man;
        string       name;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [31:0] exp_man, input string name);
        vecs[idx].a[0] = a0; vecs[idx].a[1] = a1; vecs[idx].a[2] = a2; vecs[idx].a[3] = a3;
        vecs[idx].b[0] = b0; vecs[idx].b[1] = b1; vecs[idx].b[2] = b2; vecs[idx].b[3] = b3;
        vecs[idx].man  = exp_man;
        vecs[idx].name = name;
    endtask

    // One full transaction on the 4-element instance, with serialiser handshake.
    task automatic run_small(input int idx);
        int p;
        for (int i = 0; i < 4; i++) begin
            mem_a_s[i] = vecs[idx].a[i];
            mem_b_s[i] = vecs[idx].b[i];
        end
        start_s = 1'b1;
        tick();                                  // cycle 1
        start_s = 1'b0;
        chk({vecs[idx].name, "_busy1"}, 32'(busy_s), 32'd1);
        chk({vecs[idx].name, "_rden1"}, 32'(rd_en_s), 32'd1);
        chk({vecs[idx].name, "_addr1"}, 32'(addr_s), 32'd0);
        p = 0;
        for (int k = 2; k <= 40 && p == 0; k++) begin
            tick();
            if (en_s) begin
                p = k;
                chk({vecs[idx].name, "_man"}, man_s, vecs[idx].man);
            end
        end
        chk({vecs[idx].name, "_en_cycle"}, 32'(p), 32'(LAT_S));
        tick();                                  // p+1
        chk({vecs[idx].name, "_en_width"}, 32'(en_s), 32'd0);
        repeat (SER_GAP - 1) tick();             // p+40
        chk({vecs[idx].name, "_busy_wait"}, 32'(busy_s), 32'd1);
        done_tx_s = 1'b1;
        tick();                                  // p+41
        done_tx_s = 1'b0;
        chk({vecs[idx].name, "_done"}, 32'(done_s), 32'd1);
        chk({vecs[idx].name, "_idle"}, 32'(busy_s), 32'd0);
        chk({vecs[idx].name, "_man_hold"}, man_s, vecs[idx].man);
        tick();
        chk({vecs[idx].name, "_done_width"}, 32'(done_s), 32'd0);
    endtask

    // One full transaction on the default instance, checking the address sweep.
    task automatic run_default(input logic [31:0] exp_man, input string name);
        int bad;
        int p;
        start_d = 1'b1;
        tick();                                  // cycle 1
        start_d = 1'b0;
        bad = 0;
        for (int k = 1; k <= 1024; k++) begin
            if (!(rd_en_d === 1'b1 && addr_d === 10'(k - 1))) bad++;
            if (k < 1024) tick();
        end
        chk({name, "_addr_sweep_bad"}, 32'(bad), 32'd0);
        tick();                                  // cycle 1025
        chk({name, "_rden_off"}, 32'(rd_en_d), 32'd0);
        chk({name, "_addr_back0"}, 32'(addr_d), 32'd0);
        p = 0;
        for (int k = 1026; k <= 1070 && p == 0; k++) begin
            tick();
            if (en_d) p = k;
        end
        chk({name, "_en_cycle"}, 32'(p), 32'(LAT_D));
        chk({name, "_man"}, man_d, exp_man);
        repeat (SER_GAP - 1) tick();
        done_tx_d = 1'b1;
        tick();
        done_tx_d = 1'b0;
        chk({name, "_done"}, 32'(done_d), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p;
        int n_en;

        reset = 1'b1;
        start_s = 1'b0; done_tx_s = 1'b0;
        start_d = 1'b0; done_tx_d = 1'b0;
        start_1 = 1'b0; done_tx_1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_a_s[i] = 8'd0;
            mem_b_s[i] = 8'd0;
        end
        for (int i = 0; i < 1024; i++) begin
            mem_a_d[i] = 8'd255;
            mem_b_d[i] = 8'd0;
        end
        tick();
        tick();
        reset = 1'b0;

        // Reset values.
        chk("rst_rden",  32'(rd_en_s), 32'd0);
        chk("rst_addr",  32'(addr_s),  32'd0);
        chk("rst_man",   man_s,        32'd0);
        chk("rst_en",    32'(en_s),    32'd0);
        chk("rst_busy",  32'(busy_s),  32'd0);
        chk("rst_done",  32'(done_s),  32'd0);

        // Vector table for the 4-element instance.
        set_vec(0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 8'd20, 8'd10, 8'd45, 32'd55,   "t1_basic");
        set_vec(1, 8'd7,  8'd99, 8'd200,8'd255,8'd7,  8'd99, 8'd200,8'd255,32'd0,    "t3_equal");
        set_vec(2, 8'd255,8'd0,  8'd255,8'd0,  8'd0,  8'd255,8'd0,  8'd255,32'd1020, "t_extreme");
        set_vec(3, 8'd1,  8'd128,8'd129,8'd64, 8'd0,  8'd129,8'd128,8'd200,32'd139,  "t_mixed");
        for (int i = 0; i < 4; i++) run_small(i);

        // done_txMAN in IDLE is ignored.
        done_tx_s = 1'b1;
        tick();
        done_tx_s = 1'b0;
        chk("idle_donetx_done", 32'(done_s), 32'd0);
        chk("idle_donetx_busy", 32'(busy_s), 32'd0);

        // Test 4: stray start / done_txMAN during ISSUE and WAIT_TX.
        for (int i = 0; i < 4; i++) begin
            mem_a_s[i] = vecs[0].a[i];
            mem_b_s[i] = vecs[0].b[i];
        end
        start_s = 1'b1;
        tick();                                  // cycle 1
        start_s = 1'b0;
        tick();                                  // cycle 2
        start_s = 1'b1;
        done_tx_s = 1'b1;
        tick();                                  // cycle 3
        start_s = 1'b0;
        done_tx_s = 1'b0;
        chk("t4_issue_addr", 32'(addr_s), 32'd2);
        chk("t4_issue_done", 32'(done_s), 32'd0);
        p = 0;
        n_en = 0;
        for (int k = 4; k <= 20; k++) begin
            tick();
            if (en_s) begin
                n_en++;
                if (p == 0) p = k;
            end
        end                                      // now cycle 20
        chk("t4_en_cycle", 32'(p), 32'(LAT_S));
        chk("t4_en_count", 32'(n_en), 32'd1);
        chk("t4_man", man_s, 32'd55);
        start_s = 1'b1;
        tick();                                  // cycle 21, WAIT_TX
        start_s = 1'b0;
        chk("t4_wait_start_rden", 32'(rd_en_s), 32'd0);
        chk("t4_wait_start_busy", 32'(busy_s),  32'd1);
        repeat (p + SER_GAP - 21) tick();        // cycle p+40
        start_s = 1'b1;
        done_tx_s = 1'b1;
        tick();
        start_s = 1'b0;
        done_tx_s = 1'b0;
        chk("t4_both_done", 32'(done_s), 32'd1);
        chk("t4_both_busy", 32'(busy_s), 32'd0);
        tick();
        chk("t4_start_dropped_rden", 32'(rd_en_s), 32'd0);
        chk("t4_start_dropped_busy", 32'(busy_s),  32'd0);

        // N_ELEM=1, RD_LAT=1: ISSUE lasts one cycle.
        start_1 = 1'b1;
        tick();                                  // cycle 1
        start_1 = 1'b0;
        chk("n1_rden_c1", 32'(rd_en_1), 32'd1);
        chk("n1_addr_c1", 32'(addr_1),  32'd0);
        tick();                                  // cycle 2
        chk("n1_rden_c2", 32'(rd_en_1), 32'd0);
        chk("n1_busy_c2", 32'(busy_1),  32'd1);
        p = 0;
        for (int k = 3; k <= 20 && p == 0; k++) begin
            tick();
            if (en_1) p = k;
        end
        chk("n1_en_cycle", 32'(p), 32'(LAT_1));
        chk("n1_man", man_1, 32'd193);
        repeat (SER_GAP - 1) tick();
        done_tx_1 = 1'b1;
        tick();
        done_tx_1 = 1'b0;
        chk("n1_done", 32'(done_1), 32'd1);

        // Test 2: defaults, A=255, B=0.
        run_default(32'd261120, "t2_full");

        // Test 5: reset mid-ISSUE at addr=100, then a fresh run.
        for (int i = 0; i < 1024; i++) begin
            mem_a_d[i] = 8'(i);
            mem_b_d[i] = 8'd0;
        end
        start_d = 1'b1;
        tick();                                  // cycle 1, addr 0
        start_d = 1'b0;
        repeat (100) tick();                     // cycle 101, addr 100
        chk("t5_addr100", 32'(addr_d), 32'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_rden", 32'(rd_en_d), 32'd0);
        chk("t5_rst_addr", 32'(addr_d),  32'd0);
        chk("t5_rst_man",  man_d,        32'd0);
        chk("t5_rst_en",   32'(en_d),    32'd0);
        chk("t5_rst_busy", 32'(busy_d),  32'd0);
        chk("t5_rst_done", 32'(done_d),  32'd0);
        tick();
        chk("t5_stays_idle", 32'(busy_d), 32'd0);
        run_default(32'd130560, "t5_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
